key_number_entry: RTL and testbench
===================================

// Module: key_number_entry
//
// PURPOSE
//  Front-panel input path; the counterpart of the decimal HEX display output.
//  Debounces the four active-low push keys. Lets the user type a decimal number
//  one digit at a time from sw[3:0]. Converts the entered BCD digits to binary
//  and hands the result to the core over a valid/ready handshake.
//  The live digits are exported so the HEX driver can echo them while the user types.
//
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  cycles a synced key level must hold before it is accepted (20 ms @ 50 MHz)
//  NUM_DIGITS       4        maximum decimal digits held
//  DATA_W           16       out_data width; must be >= log2(10^NUM_DIGITS)
//
// PORTS
//  clk          in   1             50 MHz system clock
//  rst_n        in   1             asynchronous active-low reset
//  key          in   4             raw push keys, active low: [0]=enter digit [1]=backspace [2]=clear [3]=submit
//  sw           in   4             digit value to enter (binary 0..15)
//  bcd          out  4*NUM_DIGITS  entered digits, right-aligned, unused digits 0
//  digit_count  out  3             number of digits held, 0..NUM_DIGITS
//  busy         out  1             high in CONVERT and VALID states
//  entry_err    out  1             sticky; set on rejected action, cleared by next accepted action
//  out_valid    out  1             out_data holds a converted value
//  out_data     out  DATA_W        binary value of the entered number
//  out_ready    in   1             consumer accepts out_data when out_valid & out_ready
//
// BEHAVIOUR
//  Reset (async): all outputs 0; debounced key state = released (1); FSM = IDLE.
//  Input conditioning, per key:
//   - 2-flop synchroniser, then a debounce counter.
//   - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synced samples.
//   - A press event is a 1-cycle pulse on a debounced 1->0 edge. Release generates no event.
//  FSM states: IDLE, CONVERT, VALID.
//  IDLE, press events; several events in one cycle resolve by priority clear > submit > backspace > enter:
//   - clear:     digits=0, count=0, entry_err=0.
//   - submit:    if count==0, set entry_err and stay in IDLE. Otherwise go to CONVERT with acc=0, idx=MSD.
//   - backspace: if count>0, shift digits right one digit and count--. At count==0 do nothing; entry_err is not set.
//   - enter:     if sw>9 or count==NUM_DIGITS, set entry_err and leave digits unchanged.
//                Otherwise shift digits left one digit, insert sw as LSD, count++, entry_err=0.
//  CONVERT:
//   - Exactly NUM_DIGITS cycles, MSD first: acc <= acc*10 + digit[idx], truncated to DATA_W.
//   - Leading zero digits are harmless.
//   - Then go to VALID with out_data=acc.
//  Latency: submit pulse at cycle T gives the first out_valid=1 at cycle T+1+NUM_DIGITS.
//  VALID:
//   - out_valid=1; out_data stable until the handshake.
//   - On out_valid & out_ready (may be the first VALID cycle): out_valid=0 next cycle,
//     digits=0, count=0, return to IDLE.
//  All press events in CONVERT/VALID are dropped, not queued, and leave entry_err unchanged.
//   The debouncers keep running, so a key held across the return to IDLE produces no new event.
//  bcd and digit_count stay unchanged during CONVERT/VALID.
//  Reset asserted mid-CONVERT or in VALID aborts immediately; no partial result is ever presented.
//
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Bounce: key[0] toggles every 2 cycles for 20 cycles, then holds low with sw=5
//     -> exactly one enter event; bcd=16'h0005, count=1.
//  2. Entry: enter 1,2,3,4 then submit with out_ready=1
//     -> out_valid high for 1 cycle at T+5, out_data=1234, then bcd=0, count=0.
//  3. Limits: enter a 5th digit, then sw=12 enter, then submit with count=0
//     -> entry_err=1 each time, digits unchanged.
//  4. Edit: enter 9,8,7, backspace, enter 6 -> bcd=16'h0986; clear -> bcd=0, entry_err=0.
//  5. Backpressure: 9999 submitted with out_ready=0 for 50 cycles, keys pressed meanwhile
//     -> out_valid and out_data=9999 held, keys ignored; out_ready=1 -> accepted once.
//  6. Reset: rst_n low two cycles into CONVERT -> all outputs 0 immediately; no out_valid afterwards.

Source files
------------

// File: rtl/key_number_entry.sv
// Front-panel decimal entry: debounced keys, BCD digit editing,
// BCD-to-binary conversion and a valid/ready hand-off to the core.
module key_number_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_DIGITS      = 4,
  parameter int DATA_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key,
  input  logic [3:0]              sw,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [2:0]              digit_count,
  output logic                    busy,
  output logic                    entry_err,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    VALID
  } state_e;

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press;

  state_e           state_q, state_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [2:0]       count_q, count_d;
  logic             err_q, err_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       dig;

  // A level flips only after DEBOUNCE_CYCLES differing samples in a row
  always_comb begin
    db_d = db_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1))
          db_d[k] = sync2_q[k];
        else
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  assign press = db_q & ~db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      db_q    <= 4'hF;
      for (int k = 0; k < 4; k++)
        cnt_q[k] <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      for (int k = 0; k < 4; k++)
        cnt_q[k] <= cnt_d[k];
    end
  end

  assign dig = bcd_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    err_d   = err_q;
    acc_d   = acc_q;
    data_d  = data_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        // Simultaneous events: clear > submit > backspace > enter
        if (press[2]) begin
          bcd_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (press[3]) begin
          if (count_q == 3'd0) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = CONVERT;
            acc_d   = '0;
            idx_d   = IDX_W'(NUM_DIGITS - 1);
          end
        end else if (press[1]) begin
          if (count_q != 3'd0) begin
            bcd_d   = {4'h0, bcd_q[BW-1:4]};
            count_d = count_q - 3'd1;
            err_d   = 1'b0;
          end
        end else if (press[0]) begin
          if (sw > 4'd9 || count_q == 3'(NUM_DIGITS)) begin
            err_d = 1'b1;
          end else begin
            bcd_d   = {bcd_q[BW-5:0], sw};
            count_d = count_q + 3'd1;
            err_d   = 1'b0;
          end
        end
      end
      CONVERT: begin
        acc_d = acc_q * DATA_W'(10) + DATA_W'(dig);
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          data_d  = acc_d;
          state_d = VALID;
        end
      end
      VALID: begin
        if (out_ready) begin
          bcd_d   = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign bcd         = bcd_q;
  assign digit_count = count_q;
  assign entry_err   = err_q;
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == VALID);
  assign out_data    = data_q;

endmodule

// File: tb/tb_key_number_entry.sv
// Directed bench for key_number_entry; hand-off values are checked
// through a scoreboard queue drained by an independent monitor.
module tb_key_number_entry;

  localparam int ND = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    key = 4'hF;
  logic [3:0]    sw = 4'h0;
  logic          out_ready = 1'b0;
  logic [4*ND-1:0] bcd;
  logic [2:0]    digit_count;
  logic          busy;
  logic          entry_err;
  logic          out_valid;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  key_number_entry #(
    .DEBOUNCE_CYCLES(4),
    .NUM_DIGITS(ND),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .sw(sw),
    .bcd(bcd),
    .digit_count(digit_count),
    .busy(busy),
    .entry_err(entry_err),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input logic [3:0] v);
    sw = v;
    key[k] = 1'b0;
    cyc(10);
    key[k] = 1'b1;
    cyc(10);
  endtask

  task automatic panel(input string nm, input logic [15:0] b,
                       input logic [2:0] c, input logic e);
    @(negedge clk);
    chk({nm, "_bcd"}, 64'(bcd), 64'(b));
    chk({nm, "_cnt"}, 64'(digit_count), 64'(c));
    chk({nm, "_err"}, 64'(entry_err), 64'(e));
  endtask

  // Monitor: latency from CONVERT entry, hand-off data, single-beat valid
  int   ncyc = 0;
  int   rise = 0;
  logic busy_p = 1'b0;
  logic val_p = 1'b0;
  logic chk_low = 1'b0;
  logic [DW-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_p  = 1'b0;
      val_p   = 1'b0;
      chk_low = 1'b0;
    end else begin
      ncyc++;
      if (busy && !busy_p)
        rise = ncyc;
      if (out_valid && !val_p)
        chk("latency", 64'(ncyc - rise), 64'(ND));
      if (chk_low) begin
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk_low = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e));
        end
        chk_low = 1'b1;
      end
      busy_p = busy;
      val_p  = out_valid;
    end
  end

  initial begin
    bit found;

    #1;
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_flags", 64'({digit_count, busy, entry_err, out_valid}), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    // 1: bouncing enter key yields a single event
    sw = 4'd5;
    for (int i = 0; i < 10; i++) begin
      key[0] = ~key[0];
      cyc(2);
    end
    key[0] = 1'b0;
    cyc(10);
    key[0] = 1'b1;
    cyc(10);
    panel("bounce", 16'h0005, 3'd1, 1'b0);
    press(2, 4'd0);

    // 2: 1234 submitted with consumer ready
    press(0, 4'd1);
    press(0, 4'd2);
    press(0, 4'd3);
    press(0, 4'd4);
    panel("entry", 16'h1234, 3'd4, 1'b0);
    out_ready = 1'b1;
    exp_q.push_back(16'd1234);
    press(3, 4'd0);
    panel("after_sub", 16'h0000, 3'd0, 1'b0);
    chk("idle_busy", 64'(busy), 64'd0);
    out_ready = 1'b0;

    // 3: rejected actions
    press(0, 4'd1);
    press(0, 4'd2);
    press(0, 4'd3);
    press(0, 4'd4);
    press(0, 4'd5);
    panel("fifth", 16'h1234, 3'd4, 1'b1);
    press(2, 4'd0);
    panel("clr1", 16'h0000, 3'd0, 1'b0);
    press(0, 4'd7);
    press(0, 4'd12);
    panel("sw12", 16'h0007, 3'd1, 1'b1);
    press(2, 4'd0);
    press(3, 4'd0);
    panel("sub0", 16'h0000, 3'd0, 1'b1);
    chk("sub0_busy", 64'(busy), 64'd0);

    // 4: editing
    press(2, 4'd0);
    press(0, 4'd9);
    press(0, 4'd8);
    press(0, 4'd7);
    press(1, 4'd0);
    panel("bksp", 16'h0098, 3'd2, 1'b0);
    press(0, 4'd6);
    panel("edit", 16'h0986, 3'd3, 1'b0);
    press(0, 4'd15);
    panel("edit_err", 16'h0986, 3'd3, 1'b1);
    press(2, 4'd0);
    panel("clr2", 16'h0000, 3'd0, 1'b0);

    // 5: back-pressure holds the result, keys dropped
    for (int i = 0; i < 4; i++)
      press(0, 4'd9);
    exp_q.push_back(16'd9999);
    press(3, 4'd0);
    press(0, 4'd3);
    press(2, 4'd0);
    cyc(10);
    panel("held", 16'h9999, 3'd4, 1'b0);
    chk("held_valid", 64'(out_valid), 64'd1);
    chk("held_data", 64'(out_data), 64'd9999);
    out_ready = 1'b1;
    cyc(5);
    panel("accepted", 16'h0000, 3'd0, 1'b0);
    chk("acc_busy", 64'(busy), 64'd0);
    out_ready = 1'b0;

    // 6: reset during conversion
    press(0, 4'd5);
    press(0, 4'd6);
    panel("pre_rst", 16'h0056, 3'd2, 1'b0);
    out_ready = 1'b1;
    key[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1'b1;
    end
    chk("busy_seen", 64'(found), 64'd1);
    key[3] = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_conv", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_bcd", 64'(bcd), 64'd0);
    chk("arst_flags", 64'({digit_count, busy, entry_err, out_valid}), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    panel("post_rst", 16'h0000, 3'd0, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
